// File: rtl/cta_launch_arbiter.sv
// Round-robin arbiter sharing the CTA host-request port between NUM_REQ launch sources,
// with an ownership table that routes each "workgroup done" back to its launching source.
module cta_launch_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int DESC_WIDTH  = 416,
   parameter int TABLE_DEPTH = 8,
   parameter int WG_ID_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   input  logic [NUM_REQ*WG_ID_WIDTH-1:0]  req_wg_id_i,
   input  logic [NUM_REQ*DESC_WIDTH-1:0]   req_desc_i,
   output logic                            host_req_valid_o,
   input  logic                            host_req_ready_i,
   output logic [WG_ID_WIDTH-1:0]          host_req_wg_id_o,
   output logic [DESC_WIDTH-1:0]           host_req_desc_o,
   input  logic                            host_rsp_valid_i,
   output logic                            host_rsp_ready_o,
   input  logic [WG_ID_WIDTH-1:0]          host_rsp_wg_id_i,
   output logic [NUM_REQ-1:0]              rsp_valid_o,
   input  logic [NUM_REQ-1:0]              rsp_ready_i,
   output logic [WG_ID_WIDTH-1:0]          rsp_wg_id_o,
   output logic [$clog2(TABLE_DEPTH):0]    inflight_cnt_o,
   output logic                            err_unmatched_o
);

   localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
   localparam int CNT_W = $clog2(TABLE_DEPTH) + 1;

   logic                   out_valid_q, out_valid_d;
   logic [WG_ID_WIDTH-1:0] out_wg_id_q, out_wg_id_d;
   logic [DESC_WIDTH-1:0]  out_desc_q, out_desc_d;
   logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;

   logic [TABLE_DEPTH-1:0] tbl_valid_q, tbl_valid_d;
   logic [WG_ID_WIDTH-1:0] tbl_wg_id_q [TABLE_DEPTH];
   logic [WG_ID_WIDTH-1:0] tbl_wg_id_d [TABLE_DEPTH];
   logic [SRC_W-1:0]       tbl_src_q [TABLE_DEPTH];
   logic [SRC_W-1:0]       tbl_src_d [TABLE_DEPTH];

   logic                   rsp_valid_q, rsp_valid_d;
   logic [WG_ID_WIDTH-1:0] rsp_wg_id_q, rsp_wg_id_d;
   logic [SRC_W-1:0]       rsp_src_q, rsp_src_d;
   logic                   err_q, err_d;

   logic                   grant_found;
   logic [SRC_W-1:0]       grant_idx;
   logic [SRC_W-1:0]       arb_cand;
   logic                   alloc_found;
   logic [IDX_W-1:0]       alloc_idx;
   logic                   hit_found;
   logic [IDX_W-1:0]       hit_idx;
   logic [CNT_W-1:0]       cnt;
   logic                   load_en;
   logic                   rsp_owner_ready;
   logic                   rsp_accept;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      arb_cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         arb_cand = SRC_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!grant_found && req_valid_i[arb_cand]) begin
            grant_found = 1'b1;
            grant_idx   = arb_cand;
         end
      end
   end

   // Lowest free slot for allocation, lowest matching slot for a done; both use pre-update state
   always_comb begin
      alloc_found = 1'b0;
      alloc_idx   = '0;
      hit_found   = 1'b0;
      hit_idx     = '0;
      cnt         = '0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
         cnt = cnt + CNT_W'(tbl_valid_q[i]);
         if (!alloc_found && !tbl_valid_q[i]) begin
            alloc_found = 1'b1;
            alloc_idx   = IDX_W'(i);
         end
         if (!hit_found && tbl_valid_q[i] && (tbl_wg_id_q[i] == host_rsp_wg_id_i)) begin
            hit_found = 1'b1;
            hit_idx   = IDX_W'(i);
         end
      end
   end

   assign rsp_owner_ready  = rsp_ready_i[rsp_src_q];
   assign host_rsp_ready_o = rst_n && (!rsp_valid_q || rsp_owner_ready);
   assign rsp_accept       = host_rsp_valid_i && host_rsp_ready_o;
   assign load_en          = rst_n && grant_found && alloc_found &&
                             (!out_valid_q || host_req_ready_i);

   always_comb begin
      req_ready_o = '0;
      if (load_en) req_ready_o[grant_idx] = 1'b1;
      rsp_valid_o = '0;
      if (rsp_valid_q) rsp_valid_o[rsp_src_q] = 1'b1;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_wg_id_d = out_wg_id_q;
      out_desc_d  = out_desc_q;
      rr_ptr_d    = rr_ptr_q;
      tbl_valid_d = tbl_valid_q;
      tbl_wg_id_d = tbl_wg_id_q;
      tbl_src_d   = tbl_src_q;
      rsp_valid_d = rsp_valid_q;
      rsp_wg_id_d = rsp_wg_id_q;
      rsp_src_d   = rsp_src_q;
      err_d       = rsp_accept && !hit_found;

      if (load_en) begin
         out_valid_d            = 1'b1;
         out_wg_id_d            = req_wg_id_i[int'(grant_idx)*WG_ID_WIDTH +: WG_ID_WIDTH];
         out_desc_d             = req_desc_i[int'(grant_idx)*DESC_WIDTH +: DESC_WIDTH];
         rr_ptr_d               = SRC_W'((int'(grant_idx) + 1) % NUM_REQ);
         tbl_valid_d[alloc_idx] = 1'b1;
         tbl_wg_id_d[alloc_idx] = out_wg_id_d;
         tbl_src_d[alloc_idx]   = grant_idx;
      end else if (host_req_ready_i) begin
         out_valid_d = 1'b0;
      end

      if (rsp_valid_q && rsp_owner_ready) rsp_valid_d = 1'b0;
      if (rsp_accept && hit_found) begin
         tbl_valid_d[hit_idx] = 1'b0;
         rsp_valid_d          = 1'b1;
         rsp_wg_id_d          = host_rsp_wg_id_i;
         rsp_src_d            = tbl_src_q[hit_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_wg_id_q <= '0;
         out_desc_q  <= '0;
         rr_ptr_q    <= '0;
         tbl_valid_q <= '0;
         for (int i = 0; i < TABLE_DEPTH; i++) begin
            tbl_wg_id_q[i] <= '0;
            tbl_src_q[i]   <= '0;
         end
         rsp_valid_q <= 1'b0;
         rsp_wg_id_q <= '0;
         rsp_src_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_wg_id_q <= out_wg_id_d;
         out_desc_q  <= out_desc_d;
         rr_ptr_q    <= rr_ptr_d;
         tbl_valid_q <= tbl_valid_d;
         tbl_wg_id_q <= tbl_wg_id_d;
         tbl_src_q   <= tbl_src_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_wg_id_q <= rsp_wg_id_d;
         rsp_src_q   <= rsp_src_d;
         err_q       <= err_d;
      end
   end

   assign host_req_valid_o = out_valid_q;
   assign host_req_wg_id_o = out_wg_id_q;
   assign host_req_desc_o  = out_desc_q;
   assign rsp_wg_id_o      = rsp_wg_id_q;
   assign inflight_cnt_o   = cnt;
   assign err_unmatched_o  = err_q;

endmodule

// File: tb/tb_cta_launch_arbiter.sv
// Directed bench for cta_launch_arbiter: fairness, table full, alloc+free overlap,
// response backpressure, unmatched done and mid-run reset.
module tb_cta_launch_arbiter;

   localparam int NUM_REQ = 2;
   localparam int DW      = 416;
   localparam int TD      = 8;
   localparam int WW      = 32;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*WW-1:0] req_wg_id;
   logic [NUM_REQ*DW-1:0] req_desc;
   logic                  host_req_valid;
   logic                  host_req_ready;
   logic [WW-1:0]         host_req_wg_id;
   logic [DW-1:0]         host_req_desc;
   logic                  host_rsp_valid;
   logic                  host_rsp_ready;
   logic [WW-1:0]         host_rsp_wg_id;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [WW-1:0]         rsp_wg_id;
   logic [$clog2(TD):0]   inflight_cnt;
   logic                  err_unmatched;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   cta_launch_arbiter #(
      .NUM_REQ(NUM_REQ), .DESC_WIDTH(DW), .TABLE_DEPTH(TD), .WG_ID_WIDTH(WW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_wg_id_i(req_wg_id), .req_desc_i(req_desc),
      .host_req_valid_o(host_req_valid), .host_req_ready_i(host_req_ready),
      .host_req_wg_id_o(host_req_wg_id), .host_req_desc_o(host_req_desc),
      .host_rsp_valid_i(host_rsp_valid), .host_rsp_ready_o(host_rsp_ready),
      .host_rsp_wg_id_i(host_rsp_wg_id),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_wg_id_o(rsp_wg_id),
      .inflight_cnt_o(inflight_cnt), .err_unmatched_o(err_unmatched)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk_desc(input logic [31:0] id);
      return {13{32'hD000_0000 ^ id}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int s, input logic v, input logic [31:0] id);
      req_valid[s]          = v;
      req_wg_id[s*WW +: WW] = id;
      req_desc[s*DW +: DW]  = mk_desc(id);
   endtask

   task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int exp_order [8] = '{0, 16, 1, 17, 2, 18, 3, 19};

   initial begin
      rst_n          = 1'b0;
      req_valid      = '0;
      req_wg_id      = '0;
      req_desc       = '0;
      host_req_ready = 1'b1;
      host_rsp_valid = 1'b0;
      host_rsp_wg_id = '0;
      rsp_ready      = 2'b11;
      set_src(0, 1'b1, 7);
      set_src(1, 1'b1, 8);
      tick();
      tick();
      check_output("rst_host_req_valid", host_req_valid, 0);
      check_output("rst_rsp_valid", rsp_valid, 0);
      check_output("rst_err", err_unmatched, 0);
      check_output("rst_cnt", inflight_cnt, 0);
      check_output("rst_req_ready", req_ready, 0);
      check_output("rst_host_rsp_ready", host_rsp_ready, 0);
      check_output("rst_host_req_wg", host_req_wg_id, 0);

      // Fairness: both sources stream, table fills to 8
      rst_n = 1'b1;
      set_src(0, 1'b1, 0);
      set_src(1, 1'b1, 16);
      for (int k = 0; k < 8; k++) begin
         #1;
         check_output("fair_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         check_output("fair_valid", host_req_valid, 1);
         check_output("fair_wg", host_req_wg_id, exp_order[k]);
         check_output("fair_cnt", inflight_cnt, k + 1);
         if (k == 0) check_output("fair_desc", host_req_desc, mk_desc(0));
         if (k % 2 == 0) begin
            if (k / 2 < 3) set_src(0, 1'b1, k / 2 + 1);
            else set_src(0, 1'b0, 0);
         end else begin
            if (k / 2 < 3) set_src(1, 1'b1, 16 + k / 2 + 1);
            else set_src(1, 1'b0, 0);
         end
      end

      // Table full: 9th request stalls
      set_src(0, 1'b1, 4);
      #1;
      check_output("full_ready", req_ready, 2'b00);
      tick();
      check_output("full_drain", host_req_valid, 0);
      check_output("full_cnt", inflight_cnt, 8);
      check_output("full_ready_hold", req_ready, 2'b00);

      // Done for id 3 frees a slot; pending launch granted the next cycle
      host_rsp_valid = 1'b1;
      host_rsp_wg_id = 3;
      #1;
      check_output("free_rsp_ready", host_rsp_ready, 1);
      check_output("free_no_grant", req_ready, 2'b00);
      tick();
      check_output("free_rsp_valid", rsp_valid, 2'b01);
      check_output("free_rsp_wg", rsp_wg_id, 3);
      host_rsp_valid = 1'b0;
      #1;
      check_output("free_grant", req_ready, 2'b01);
      tick();
      check_output("free_launch_valid", host_req_valid, 1);
      check_output("free_launch_wg", host_req_wg_id, 4);
      check_output("free_launch_desc", host_req_desc, mk_desc(4));
      check_output("free_cnt", inflight_cnt, 8);
      set_src(0, 1'b0, 0);

      // CTA not ready: output register holds
      host_req_ready = 1'b0;
      tick();
      check_output("hold_valid", host_req_valid, 1);
      check_output("hold_wg", host_req_wg_id, 4);
      check_output("rsp_drain", rsp_valid, 2'b00);

      // Response backpressure from owner src1
      rsp_ready      = 2'b00;
      host_rsp_valid = 1'b1;
      host_rsp_wg_id = 16;
      #1;
      check_output("bp_rsp_ready", host_rsp_ready, 1);
      tick();
      check_output("bp_rsp_valid", rsp_valid, 2'b10);
      check_output("bp_rsp_wg", rsp_wg_id, 16);
      check_output("bp_cnt", inflight_cnt, 7);
      host_rsp_wg_id = 17;
      #1;
      check_output("bp_rsp_stall", host_rsp_ready, 0);
      tick();
      check_output("bp_hold_valid", rsp_valid, 2'b10);
      check_output("bp_hold_wg", rsp_wg_id, 16);

      // Simultaneous alloc (id 20) and free (id 17): count unchanged
      rsp_ready      = 2'b10;
      host_req_ready = 1'b1;
      set_src(1, 1'b1, 20);
      #1;
      check_output("sim_rsp_ready", host_rsp_ready, 1);
      check_output("sim_grant", req_ready, 2'b10);
      tick();
      check_output("sim_rsp_valid", rsp_valid, 2'b10);
      check_output("sim_rsp_wg", rsp_wg_id, 17);
      check_output("sim_req_wg", host_req_wg_id, 20);
      check_output("sim_cnt", inflight_cnt, 7);
      host_rsp_valid = 1'b0;
      set_src(1, 1'b0, 0);
      rsp_ready = 2'b11;
      tick();
      check_output("sim_rsp_done", rsp_valid, 2'b00);
      check_output("sim_req_done", host_req_valid, 0);

      // Unmatched done id
      host_rsp_valid = 1'b1;
      host_rsp_wg_id = 99;
      #1;
      check_output("unm_rsp_ready", host_rsp_ready, 1);
      tick();
      check_output("unm_err", err_unmatched, 1);
      check_output("unm_rsp_valid", rsp_valid, 2'b00);
      check_output("unm_cnt", inflight_cnt, 7);
      host_rsp_valid = 1'b0;
      tick();
      check_output("unm_err_clear", err_unmatched, 0);

      // Reset while a launch is held and the table is populated
      host_req_ready = 1'b0;
      set_src(0, 1'b1, 21);
      #1;
      check_output("pre_rst_grant", req_ready, 2'b01);
      tick();
      check_output("pre_rst_valid", host_req_valid, 1);
      check_output("pre_rst_cnt", inflight_cnt, 8);
      set_src(0, 1'b1, 40);
      set_src(1, 1'b1, 50);
      rst_n = 1'b0;
      #1;
      check_output("in_rst_ready", req_ready, 2'b00);
      tick();
      check_output("mid_rst_valid", host_req_valid, 0);
      check_output("mid_rst_cnt", inflight_cnt, 0);
      check_output("mid_rst_rsp", rsp_valid, 2'b00);
      check_output("mid_rst_err", err_unmatched, 0);
      rst_n = 1'b1;
      host_req_ready = 1'b1;
      #1;
      check_output("post_rst_grant", req_ready, 2'b01);
      tick();
      check_output("post_rst_wg", host_req_wg_id, 40);
      check_output("post_rst_cnt", inflight_cnt, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
